// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counter timer with interrupt output (CTRL/PRESET/COUNT).
// Optional TC_IRQ_LATCH_EN: mode-1 interrupt flag latches until the next CTRL write.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_flag;

  logic        w_sel;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_mode1;
  logic        w_cnt_done;
  logic        w_unused;

  assign w_sel       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
  assign w_wr        = w_sel && we && (byteen == 4'b1111);
  assign w_wr_ctrl   = w_wr && (addr[3:2] == 2'b00);
  assign w_wr_preset = w_wr && (addr[3:2] == 2'b01);
  assign w_mode1     = (r_mode == 2'b01);
  assign w_cnt_done  = (r_count <= 32'd1);
  assign w_unused    = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Auto-reload goes straight from INT to LOAD so the mode-1 period is PRESET+2.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (r_en) w_next = S_LOAD;
      S_LOAD: w_next = S_CNT;
      S_CNT: begin
        if (!r_en) begin
          w_next = S_IDLE;
        end else if (w_cnt_done) begin
          w_next = S_INT;
        end
      end
      S_INT: begin
        if (w_mode1 && r_en) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en     <= 1'b0;
      r_mode   <= 2'b00;
      r_im     <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
    end else begin
      // A CPU CTRL write takes priority over the one-shot EN clear in INT.
      if (w_wr_ctrl) begin
        r_en   <= wdata[0];
        r_mode <= wdata[2:1];
        r_im   <= wdata[3];
      end else if ((r_state == S_INT) && !w_mode1) begin
        r_en <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= wdata;
      end

      if (r_state == S_LOAD) begin
        r_count <= r_preset;
      end else if ((r_state == S_CNT) && r_en) begin
        r_count <= w_cnt_done ? '0 : r_count - 32'd1;
      end

      if (w_wr_ctrl) begin
        r_flag <= 1'b0;
      end else if ((r_state == S_CNT) && r_en && w_cnt_done) begin
        r_flag <= 1'b1;
`ifdef TC_IRQ_LATCH_EN
      end
`else
      end else if ((r_state == S_INT) && w_mode1) begin
        r_flag <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    irq   = r_im & r_flag;
    rdata = '0;
    if (w_sel) begin
      case (addr[3:2])
        2'b00:   rdata = {28'd0, r_im, r_mode, r_en};
        2'b01:   rdata = r_preset;
        2'b10:   rdata = r_count;
        default: rdata = '0;
      endcase
    end
  end

endmodule
